board_reset_sequencer: RTL and testbench
========================================

Name: board_reset_sequencer

Overview:
Board-level reset and clock-generator sequencer.
- Merges N raw reset requests (config-done, push-button, software) into one debounced request.
- Brings up the external clock generator: RST_n and OE_n pins, with a timed hold.
- Waits for PLL lock, then releases per-domain resets in a staggered order.
- Sits in the board top between the pins and the system interconnect instance; replaces hand-tied reset and enable assignments.

Parameters:
- NUM_SOURCES, 3: raw reset request inputs.
- SRC_ACTIVE_LOW, 3'b011: per-source polarity; bit=1 means that source requests reset when low.
- NUM_OUTPUTS, 4: staged active-high reset outputs.
- DEBOUNCE_CYCLES, 50000: quiet cycles required on all sources before release starts.
- CLKGEN_HOLD_CYCLES, 5000: cycles clkgen_rst_n is held low before release.
- LOCK_TIMEOUT_CYCLES, 1000000: cycles to wait for pll_locked before retrying the clock generator.
- STAGE_GAP_CYCLES, 16: cycles between consecutive rst_out releases.
- CNT_W, derived: clog2(max of the cycle parameters)+1; not overridable.

Ports:
- clk_clk, in, 1: sole clock.
- reset_reset, in, 1: asynchronous, active-high; full cold restart.
- src_reset_in, in, NUM_SOURCES: raw asynchronous reset requests.
- pll_locked, in, 1: PLL lock; asynchronous.
- clkgen_rst_n, out, 1: clock generator reset pin.
- clkgen_oe_n, out, 1: clock generator output-enable pin.
- rst_out, out, NUM_OUTPUTS: per-domain resets, active-high.
- all_released, out, 1: high only in RUN.
- reset_cause, out, NUM_SOURCES: sticky; sources active at last entry to DEBOUNCE.
- lock_timeout, out, 1: sticky; at least one lock timeout occurred.
- lost_lock, out, 1: sticky; pll_locked fell during RELEASE or RUN.
- state_dbg, out, 3: FSM state encoding.

Behaviour:
- Reset is asynchronous and active-high on reset_reset. All flops clear on assertion.
  - Reset values: clkgen_rst_n=0, clkgen_oe_n=1, rst_out=all ones, all_released=0, reset_cause=0, lock_timeout=0, lost_lock=0, state=CLKGEN_HOLD, counter=0.
- Input synchronisation:
  - Each src_reset_in bit and pll_locked pass through a 2-flop synchroniser.
  - Polarity is normalised after sync: req[i] = sync[i] XOR SRC_ACTIVE_LOW[i].
  - any_req = OR of req.
- FSM states and transitions:
  - CLKGEN_HOLD (0): clkgen_rst_n=0, clkgen_oe_n=1. Count CLKGEN_HOLD_CYCLES, then go to DEBOUNCE with clkgen_up set. clkgen_up is an internal flag, cleared only by reset_reset.
  - DEBOUNCE (1): clkgen_rst_n=1, clkgen_oe_n=0. Counter clears on every cycle any_req=1. After DEBOUNCE_CYCLES consecutive cycles of any_req=0, go to WAIT_LOCK.
  - WAIT_LOCK (2): count while pll_locked_sync=0. pll_locked_sync=1 goes to RELEASE with the counter cleared. Count reaching LOCK_TIMEOUT_CYCLES sets lock_timeout and goes to CLKGEN_HOLD (generator retry).
  - RELEASE (3): rst_out[0] clears on entry. Each subsequent bit clears STAGE_GAP_CYCLES after the previous one, in index order. One cycle after rst_out[NUM_OUTPUTS-1] clears, go to RUN.
  - RUN (4): all_released=1, rst_out=0.
- Abort rules, evaluated in priority order:
  1. any_req=1 in WAIT_LOCK, RELEASE or RUN: rst_out=all ones on the next edge, reset_cause<=req, go to DEBOUNCE. The clock generator is not re-reset.
  2. pll_locked_sync falling in RELEASE or RUN: rst_out=all ones next edge, lost_lock<=1, go to WAIT_LOCK.
- reset_cause is also loaded with req on every DEBOUNCE cycle in which any_req=1.
- Latency: raw source edge to rst_out all ones = 3 clk_clk edges (2 sync + 1 register).
- NUM_OUTPUTS=1: RELEASE lasts exactly 1 cycle; no gap is applied.
- rst_out, clkgen_rst_n, clkgen_oe_n and all_released are registered outputs, glitch-free.
- Counters saturate and never wrap.
- reset_reset asserted mid-sequence returns everything to the reset values immediately and asynchronously.

Decomposition:
- Shared package board_pkg:
  - FSM state enum (3-bit encoding above).
  - Default cycle constants for 50 MHz.
  - Helper function cnt_width(max_cycles).
- Sub-module reset_sync_bus, parametrised WIDTH. Instantiated once for src_reset_in and once for pll_locked.

Test Plan (params NUM_SOURCES=3, SRC_ACTIVE_LOW=3'b011, NUM_OUTPUTS=4, DEBOUNCE=4, CLKGEN_HOLD=8, LOCK_TIMEOUT=32, STAGE_GAP=2):
1. Cold start: pulse reset_reset, sources idle, pll_locked=1 from time 0 -> clkgen_rst_n rises 8 cycles after reset release; rst_out steps 1111→1110→1100→1000→0000 at 2-cycle spacing; all_released=1 one cycle after the last step.
2. Bouncing button: toggle src_reset_in[1] low/high every 3 cycles for 20 cycles during DEBOUNCE -> no release until 4 quiet cycles; reset_cause=3'b010.
3. No lock: hold pll_locked=0 -> at 32 cycles in WAIT_LOCK, lock_timeout=1 and clkgen_rst_n=0 for 8 cycles. Raise lock on the retry -> normal release.
4. Lock loss in RUN: drop pll_locked for 5 cycles -> rst_out=1111 3 cycles after the drop; lost_lock=1; clkgen_rst_n stays 1; re-release after lock returns.
5. Software reset mid-RELEASE: assert src_reset_in[2] (active-high) after rst_out=1100 -> rst_out=1111 within 3 cycles, state=DEBOUNCE, clkgen untouched, reset_cause=3'b100.
6. Async reset mid-RUN: assert reset_reset between clock edges -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the board reset sequencer.
package board_pkg;

  // Sequencer states; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    ST_CLKGEN_HOLD = 3'd0,
    ST_DEBOUNCE    = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_RELEASE     = 3'd3,
    ST_RUN         = 3'd4
  } seq_state_e;

  // Default timing for a 50 MHz board clock.
  localparam int DEF_DEBOUNCE_CYCLES     = 50000;    // 1 ms
  localparam int DEF_CLKGEN_HOLD_CYCLES  = 5000;     // 100 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;  // 20 ms
  localparam int DEF_STAGE_GAP_CYCLES    = 16;

  // Counter width able to hold max_cycles with one bit of headroom.
  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_bus.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module reset_sync_bus #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Capture each bit into the clock domain through two flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/board_reset_sequencer.sv
// Board reset sequencer: debounces reset requests, brings up the external
// clock generator, waits for PLL lock and releases domain resets in order.
module board_reset_sequencer
  import board_pkg::*;
#(
  parameter int                     NUM_SOURCES         = 3,
  parameter logic [NUM_SOURCES-1:0] SRC_ACTIVE_LOW      = 3'b011,
  parameter int                     NUM_OUTPUTS         = 4,
  parameter int                     DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int                     CLKGEN_HOLD_CYCLES  = DEF_CLKGEN_HOLD_CYCLES,
  parameter int                     LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int                     STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NUM_SOURCES-1:0] src_reset_in,
  input  logic                   pll_locked,
  output logic                   clkgen_rst_n,
  output logic                   clkgen_oe_n,
  output logic [NUM_OUTPUTS-1:0] rst_out,
  output logic                   all_released,
  output logic [NUM_SOURCES-1:0] reset_cause,
  output logic                   lock_timeout,
  output logic                   lost_lock,
  output logic [2:0]             state_dbg
);

  localparam int MAX_CYCLES = max_int(max_int(DEBOUNCE_CYCLES, CLKGEN_HOLD_CYCLES),
                                      max_int(LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES));
  localparam int CNT_W = cnt_width(MAX_CYCLES);

  // Terminal counts: the counter holds the number of cycles already spent.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLKGEN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

  logic [NUM_SOURCES-1:0] w_src_sync;
  logic [NUM_SOURCES-1:0] w_req;
  logic                   w_any_req;
  logic                   w_lock_sync;
  logic                   w_lock_fall;
  logic                   r_lock_prev;

  seq_state_e             r_state;
  seq_state_e             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_cnt_inc;

  logic                   r_clkgen_up;
  logic                   r_clkgen_rst_n;
  logic                   r_clkgen_oe_n;
  logic [NUM_OUTPUTS-1:0] r_rst_out;
  logic                   r_all_released;
  logic [NUM_SOURCES-1:0] r_reset_cause;
  logic                   r_lock_timeout;
  logic                   r_lost_lock;

  logic                   w_clkgen_up_nxt;
  logic                   w_clkgen_on_nxt;
  logic [NUM_OUTPUTS-1:0] w_rst_out_nxt;
  logic                   w_all_released_nxt;
  logic [NUM_SOURCES-1:0] w_reset_cause_nxt;
  logic                   w_lock_timeout_nxt;
  logic                   w_lost_lock_nxt;

  reset_sync_bus #(.WIDTH(NUM_SOURCES)) u_src_sync (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_async (src_reset_in),
    .o_sync  (w_src_sync)
  );

  reset_sync_bus #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_async (pll_locked),
    .o_sync  (w_lock_sync)
  );

  // Requests are normalised to active-high after synchronisation.
  assign w_req       = w_src_sync ^ SRC_ACTIVE_LOW;
  assign w_any_req   = |w_req;
  assign w_lock_fall = r_lock_prev & ~w_lock_sync;
  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // State register, shared cycle counter and lock history for edge detection.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= ST_CLKGEN_HOLD;
      r_cnt       <= '0;
      r_lock_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lock_prev <= w_lock_sync;
    end
  end

  // Next-state logic; a new request outranks a lock loss in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    case (r_state)
      ST_CLKGEN_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_DEBOUNCE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (w_any_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_any_req) begin
          w_state_nxt = ST_DEBOUNCE;
          w_cnt_nxt   = '0;
        end else if (w_lock_sync) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = ST_CLKGEN_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        if (w_any_req) begin
          w_state_nxt = ST_DEBOUNCE;
          w_cnt_nxt   = '0;
        end else if (w_lock_fall) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_rst_out == '0) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (w_any_req) begin
          w_state_nxt = ST_DEBOUNCE;
        end else if (w_lock_fall) begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      default: begin
        w_state_nxt = ST_CLKGEN_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Next output values, derived from the transition being taken.
  always_comb begin
    w_clkgen_up_nxt    = r_clkgen_up;
    w_reset_cause_nxt  = r_reset_cause;
    w_lock_timeout_nxt = r_lock_timeout;
    w_lost_lock_nxt    = r_lost_lock;
    if (r_state == ST_CLKGEN_HOLD && w_state_nxt == ST_DEBOUNCE) begin
      w_clkgen_up_nxt = 1'b1;
    end
    if (r_state != ST_CLKGEN_HOLD && w_state_nxt == ST_DEBOUNCE && w_any_req) begin
      w_reset_cause_nxt = w_req;
    end
    if (r_state == ST_WAIT_LOCK && w_state_nxt == ST_CLKGEN_HOLD) begin
      w_lock_timeout_nxt = 1'b1;
    end
    if ((r_state == ST_RELEASE || r_state == ST_RUN) && w_state_nxt == ST_WAIT_LOCK) begin
      w_lost_lock_nxt = 1'b1;
    end
    // Entry into RELEASE arrives with all ones, so one shift clears bit 0.
    case (w_state_nxt)
      ST_RELEASE: begin
        if (r_state != ST_RELEASE || r_cnt == GAP_LAST) begin
          w_rst_out_nxt = r_rst_out << 1;
        end else begin
          w_rst_out_nxt = r_rst_out;
        end
      end
      ST_RUN:  w_rst_out_nxt = '0;
      default: w_rst_out_nxt = '1;
    endcase
    w_clkgen_on_nxt    = w_clkgen_up_nxt && (w_state_nxt != ST_CLKGEN_HOLD);
    w_all_released_nxt = (w_state_nxt == ST_RUN);
  end

  // Registered pins so nothing toggles combinationally on the board.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_clkgen_up    <= 1'b0;
      r_clkgen_rst_n <= 1'b0;
      r_clkgen_oe_n  <= 1'b1;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
      r_reset_cause  <= '0;
      r_lock_timeout <= 1'b0;
      r_lost_lock    <= 1'b0;
    end else begin
      r_clkgen_up    <= w_clkgen_up_nxt;
      r_clkgen_rst_n <= w_clkgen_on_nxt;
      r_clkgen_oe_n  <= ~w_clkgen_on_nxt;
      r_rst_out      <= w_rst_out_nxt;
      r_all_released <= w_all_released_nxt;
      r_reset_cause  <= w_reset_cause_nxt;
      r_lock_timeout <= w_lock_timeout_nxt;
      r_lost_lock    <= w_lost_lock_nxt;
    end
  end

  assign clkgen_rst_n = r_clkgen_rst_n;
  assign clkgen_oe_n  = r_clkgen_oe_n;
  assign rst_out      = r_rst_out;
  assign all_released = r_all_released;
  assign reset_cause  = r_reset_cause;
  assign lock_timeout = r_lock_timeout;
  assign lost_lock    = r_lost_lock;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Bench for board_reset_sequencer: directed scenarios followed by random
// request / lock-loss traffic, checked every cycle against a phase model.
module tb_board_reset_sequencer;

  localparam int NS   = 3;
  localparam int NO   = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TO   = 32;
  localparam int GAP  = 2;
  localparam logic [NS-1:0] SRC_AL   = 3'b011;
  // No request: active-low sources high, active-high sources low.
  localparam logic [NS-1:0] SRC_IDLE = 3'b011;

  localparam int PH_HOLD = 0;
  localparam int PH_DEB  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;

  logic          clk;
  logic          reset_reset;
  logic [NS-1:0] src_reset_in;
  logic          pll_locked;
  logic          clkgen_rst_n;
  logic          clkgen_oe_n;
  logic [NO-1:0] rst_out;
  logic          all_released;
  logic [NS-1:0] reset_cause;
  logic          lock_timeout;
  logic          lost_lock;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles spent in it, sticky flags, and
  // the raw input history the two-cycle synchroniser delay implies.
  int            m_phase;
  int            m_t;
  logic [NS-1:0] m_cause;
  logic          m_to;
  logic          m_lost;
  logic [NS-1:0] m_sh [0:1];
  logic          m_lh [0:2];

  board_reset_sequencer #(
    .NUM_SOURCES         (NS),
    .SRC_ACTIVE_LOW      (SRC_AL),
    .NUM_OUTPUTS         (NO),
    .DEBOUNCE_CYCLES     (DEB),
    .CLKGEN_HOLD_CYCLES  (HOLD),
    .LOCK_TIMEOUT_CYCLES (TO),
    .STAGE_GAP_CYCLES    (GAP)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .src_reset_in (src_reset_in),
    .pll_locked   (pll_locked),
    .clkgen_rst_n (clkgen_rst_n),
    .clkgen_oe_n  (clkgen_oe_n),
    .rst_out      (rst_out),
    .all_released (all_released),
    .reset_cause  (reset_cause),
    .lock_timeout (lock_timeout),
    .lost_lock    (lost_lock),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_init();
    m_phase = PH_HOLD;
    m_t     = 0;
    m_cause = '0;
    m_to    = 1'b0;
    m_lost  = 1'b0;
    m_sh[0] = '0;
    m_sh[1] = '0;
    m_lh[0] = 1'b0;
    m_lh[1] = 1'b0;
    m_lh[2] = 1'b0;
  endtask

  task automatic enter_debounce(input logic [NS-1:0] req);
    m_phase = PH_DEB;
    m_t     = 0;
    m_cause = req;
  endtask

  // One clock edge of the specified behaviour, seen through the sync delay.
  task automatic model_step();
    logic [NS-1:0] req;
    logic any_req, lk, lfall;
    req     = m_sh[1] ^ SRC_AL;
    any_req = |req;
    lk      = m_lh[1];
    lfall   = m_lh[2] & ~lk;
    case (m_phase)
      PH_HOLD: begin
        m_t++;
        if (m_t == HOLD) begin m_phase = PH_DEB; m_t = 0; end
      end
      PH_DEB: begin
        if (any_req) begin
          m_t = 0;
          m_cause = req;
        end else begin
          m_t++;
          if (m_t == DEB) begin m_phase = PH_WAIT; m_t = 0; end
        end
      end
      PH_WAIT: begin
        if (any_req) enter_debounce(req);
        else if (lk) begin m_phase = PH_REL; m_t = 0; end
        else begin
          m_t++;
          if (m_t == TO) begin m_phase = PH_HOLD; m_t = 0; m_to = 1'b1; end
        end
      end
      PH_REL: begin
        if (any_req) enter_debounce(req);
        else if (lfall) begin m_phase = PH_WAIT; m_t = 0; m_lost = 1'b1; end
        else begin
          m_t++;
          if (m_t == (NO - 1) * GAP + 1) begin m_phase = PH_RUN; m_t = 0; end
        end
      end
      default: begin
        if (any_req) enter_debounce(req);
        else if (lfall) begin m_phase = PH_WAIT; m_t = 0; m_lost = 1'b1; end
      end
    endcase
    m_sh[1] = m_sh[0];
    m_sh[0] = src_reset_in;
    m_lh[2] = m_lh[1];
    m_lh[1] = m_lh[0];
    m_lh[0] = pll_locked;
  endtask

  // Expected resets: bit 0 clears at RELEASE entry, one more every GAP cycles.
  function automatic logic [NO-1:0] exp_rst();
    logic [NO-1:0] e;
    int cl;
    e = '1;
    if (m_phase == PH_RUN) begin
      e = '0;
    end else if (m_phase == PH_REL) begin
      cl = 1 + m_t / GAP;
      if (cl > NO) cl = NO;
      e = e << cl;
    end
    return e;
  endfunction

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(state_dbg),    32'(m_phase));
    chk({tag, ".rst_out"}, 32'(rst_out),      32'(exp_rst()));
    chk({tag, ".rst_n"},   32'(clkgen_rst_n), 32'(m_phase != PH_HOLD));
    chk({tag, ".oe_n"},    32'(clkgen_oe_n),  32'(m_phase == PH_HOLD));
    chk({tag, ".all_rel"}, 32'(all_released), 32'(m_phase == PH_RUN));
    chk({tag, ".cause"},   32'(reset_cause),  32'(m_cause));
    chk({tag, ".lock_to"}, 32'(lock_timeout), 32'(m_to));
    chk({tag, ".lost"},    32'(lost_lock),    32'(m_lost));
  endtask

  // Driver tasks
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input logic lock_val);
    reset_reset  = 1'b1;
    src_reset_in = SRC_IDLE;
    pll_locked   = lock_val;
    model_init();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    reset_reset = 1'b0;
  endtask

  initial begin
    int src_busy;
    int lock_busy;
    int k;
    logic found;

    reset_reset  = 1'b1;
    src_reset_in = SRC_IDLE;
    pll_locked   = 1'b1;

    // 1. Cold start with lock present.
    do_reset(1'b1);
    for (int i = 1; i <= 24; i++) begin
      tick("cold");
      case (i)
        7:  chk("cold.rst_n_still_low", 32'(clkgen_rst_n), 32'd0);
        8:  chk("cold.rst_n_rise", 32'(clkgen_rst_n), 32'd1);
        13: chk("cold.step0", 32'(rst_out), 32'b1110);
        15: chk("cold.step1", 32'(rst_out), 32'b1100);
        17: chk("cold.step2", 32'(rst_out), 32'b1000);
        19: begin
          chk("cold.step3", 32'(rst_out), 32'b0000);
          chk("cold.not_yet_run", 32'(all_released), 32'd0);
        end
        20: chk("cold.all_released", 32'(all_released), 32'd1);
        default: ;
      endcase
    end

    // 2. Bouncing push-button (active-low source 1).
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) src_reset_in[1] = ~src_reset_in[1];
      tick("bounce");
    end
    src_reset_in = SRC_IDLE;
    for (int i = 1; i <= 6; i++) begin
      tick("quiet");
      if (i == 5) chk("bounce.still_debounce", 32'(state_dbg), 32'(PH_DEB));
      if (i == 6) chk("bounce.to_wait_lock", 32'(state_dbg), 32'(PH_WAIT));
    end
    chk("bounce.cause", 32'(reset_cause), 32'b010);
    for (int i = 0; i < 20; i++) tick("bounce_rel");
    chk("bounce.run", 32'(state_dbg), 32'(PH_RUN));

    // 3. No lock: timeout, generator retry, then lock arrives.
    do_reset(1'b0);
    for (int i = 1; i <= 46; i++) begin
      tick("nolock");
      if (i == 43) chk("nolock.before_to", 32'(lock_timeout), 32'd0);
      if (i == 44) chk("nolock.timeout", 32'(lock_timeout), 32'd1);
    end
    chk("nolock.retry_rst_n", 32'(clkgen_rst_n), 32'd0);
    chk("nolock.retry_state", 32'(state_dbg), 32'(PH_HOLD));
    pll_locked = 1'b1;
    for (int i = 0; i < 30; i++) tick("relock");
    chk("nolock.run", 32'(state_dbg), 32'(PH_RUN));

    // 4. Lock loss for five cycles while running.
    pll_locked = 1'b0;
    tick("lockloss");
    tick("lockloss");
    chk("lockloss.latency", 32'(rst_out), 32'b0000);
    tick("lockloss");
    chk("lockloss.rst_out", 32'(rst_out), 32'b1111);
    chk("lockloss.flag", 32'(lost_lock), 32'd1);
    chk("lockloss.state", 32'(state_dbg), 32'(PH_WAIT));
    chk("lockloss.clkgen", 32'(clkgen_rst_n), 32'd1);
    tick("lockloss");
    tick("lockloss");
    pll_locked = 1'b1;
    for (int i = 0; i < 20; i++) tick("lockback");
    chk("lockloss.rerun", 32'(state_dbg), 32'(PH_RUN));

    // 5. Software reset (active-high source 2) once rst_out reaches 1100.
    do_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick("to_release");
      if (m_phase == PH_REL && exp_rst() == 4'b1100) found = 1'b1;
    end
    chk("sw.reached_1100", 32'(found), 32'd1);
    src_reset_in[2] = 1'b1;
    tick("sw");
    tick("sw");
    tick("sw");
    chk("sw.rst_out", 32'(rst_out), 32'b1111);
    chk("sw.state", 32'(state_dbg), 32'(PH_DEB));
    chk("sw.cause", 32'(reset_cause), 32'b100);
    chk("sw.clkgen", 32'(clkgen_rst_n), 32'd1);
    src_reset_in = SRC_IDLE;
    for (int i = 0; i < 20; i++) tick("sw_rel");
    chk("sw.run", 32'(state_dbg), 32'(PH_RUN));

    // 6. Asynchronous reset between clock edges while running.
    #3;
    reset_reset = 1'b1;
    model_init();
    #1;
    check_all("async");
    chk("async.rst_out", 32'(rst_out), 32'b1111);
    @(negedge clk);
    reset_reset = 1'b0;

    // Random request and lock-loss traffic.
    src_busy  = 0;
    lock_busy = 0;
    for (int i = 0; i < 1500; i++) begin
      if (src_busy == 0) begin
        if ($urandom_range(0, 99) < 2) begin
          k = $urandom_range(0, NS - 1);
          src_reset_in = SRC_IDLE ^ (3'b001 << k);
          src_busy = $urandom_range(1, 8);
        end
      end else begin
        src_busy--;
        if (src_busy == 0) src_reset_in = SRC_IDLE;
      end
      if (lock_busy == 0) begin
        if ($urandom_range(0, 99) < 2) begin
          pll_locked = 1'b0;
          lock_busy = $urandom_range(1, 45);
        end
      end else begin
        lock_busy--;
        if (lock_busy == 0) pll_locked = 1'b1;
      end
      tick("rand");
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
